commit_unit: RTL and testbench

Retirement stage directly downstream of the reorder buffer. It consumes the head pair of uOPs presented on the ROB commit handshake and retires them in order. Retiring updates the architectural rename table (ARAT), returns stale physical registers to the free list, and releases stores to the store buffer. It also converts exceptions and branch mispredictions, including MIPS delay-slot handling, into a one-cycle pipeline flush plus a fetch redirect.

---
 rtl/commit_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_commit_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage downstream of the reorder buffer.
// Retires up to two uOPs per beat. Retirement writes the ARAT, returns stale
// physical registers to the free list and releases stores. Exceptions and
// branch mispredicts, including MIPS delay slots, become a one-cycle flush
// plus a fetch redirect.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rob_valid / rob_ready         ROB head-pair commit handshake
//   uN_*  (N=0,1)                 per-slot uOP fields from the ROB head
//   arat_we, arat_lN, arat_pN     ARAT write ports (port 1 is younger)
//   free_we, free_pN              free-list return ports
//   store_commit                  number of stores released this cycle
//   flush, redirect_valid/pc      pipeline flush and fetch redirect
//   exc_valid, exc_code, exc_epc  exception report to CP0
module commit_unit #(
   parameter int unsigned PHYS_W     = 6,
   parameter int unsigned ARCH_W     = 5,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rob_valid,
   output logic              rob_ready,
   input  logic              u0_valid,
   input  logic              u0_committed,
   input  logic [31:0]       u0_pc,
   input  logic              u0_wen,
   input  logic [ARCH_W-1:0] u0_dstL,
   input  logic [PHYS_W-1:0] u0_dstP,
   input  logic [PHYS_W-1:0] u0_oldP,
   input  logic              u0_isBranch,
   input  logic              u0_branchTaken,
   input  logic              u0_predTaken,
   input  logic [31:0]       u0_branchAddr,
   input  logic [31:0]       u0_predAddr,
   input  logic              u0_causeExc,
   input  logic [4:0]        u0_exception,
   input  logic              u0_isStore,
   input  logic              u1_valid,
   input  logic              u1_committed,
   input  logic [31:0]       u1_pc,
   input  logic              u1_wen,
   input  logic [ARCH_W-1:0] u1_dstL,
   input  logic [PHYS_W-1:0] u1_dstP,
   input  logic [PHYS_W-1:0] u1_oldP,
   input  logic              u1_isBranch,
   input  logic              u1_branchTaken,
   input  logic              u1_predTaken,
   input  logic [31:0]       u1_branchAddr,
   input  logic [31:0]       u1_predAddr,
   input  logic              u1_causeExc,
   input  logic [4:0]        u1_exception,
   input  logic              u1_isStore,
   output logic [1:0]        arat_we,
   output logic [ARCH_W-1:0] arat_l0,
   output logic [PHYS_W-1:0] arat_p0,
   output logic [ARCH_W-1:0] arat_l1,
   output logic [PHYS_W-1:0] arat_p1,
   output logic [1:0]        free_we,
   output logic [PHYS_W-1:0] free_p0,
   output logic [PHYS_W-1:0] free_p1,
   output logic [1:0]        store_commit,
   output logic              flush,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              exc_valid,
   output logic [4:0]        exc_code,
   output logic [31:0]       exc_epc
);

   typedef enum logic [1:0] {NORMAL = 2'd0, WAIT_DS = 2'd1, FLUSH = 2'd2} state_t;

   state_t            r_state;
   logic [31:0]       r_target;
   logic [1:0]        r_arat_we;
   logic [ARCH_W-1:0] r_arat_l0, r_arat_l1;
   logic [PHYS_W-1:0] r_arat_p0, r_arat_p1;
   logic [1:0]        r_free_we;
   logic [PHYS_W-1:0] r_free_p0, r_free_p1;
   logic [1:0]        r_store_commit;
   logic              r_flush, r_redirect_valid, r_exc_valid;
   logic [31:0]       r_redirect_pc, r_exc_epc;
   logic [4:0]        r_exc_code;

   // Per-slot decode
   logic        w_beat, w_live0, w_live1, w_mis0, w_mis1;
   logic [31:0] w_tgt0, w_tgt1;

   assign w_beat  = rob_valid && (r_state != FLUSH);
   assign w_live0 = u0_valid && !u0_committed;
   assign w_live1 = u1_valid && !u1_committed;
   assign w_mis0  = u0_isBranch && ((u0_branchTaken != u0_predTaken) ||
                                    (u0_branchTaken && (u0_branchAddr != u0_predAddr)));
   assign w_mis1  = u1_isBranch && ((u1_branchTaken != u1_predTaken) ||
                                    (u1_branchTaken && (u1_branchAddr != u1_predAddr)));
   assign w_tgt0  = u0_branchTaken ? u0_branchAddr : (u0_pc + 32'd8);
   assign w_tgt1  = u1_branchTaken ? u1_branchAddr : (u1_pc + 32'd8);

   // Beat resolution: which slots retire and how the beat terminates
   logic        w_ret0, w_ret1, w_exc, w_br_flush, w_to_wait;
   logic [4:0]  w_exc_code;
   logic [31:0] w_exc_epc, w_br_tgt;

   always_comb begin
      w_ret0     = 1'b0;
      w_ret1     = 1'b0;
      w_exc      = 1'b0;
      w_br_flush = 1'b0;
      w_to_wait  = 1'b0;
      w_exc_code = 5'd0;
      w_exc_epc  = 32'd0;
      w_br_tgt   = 32'd0;
      if (w_beat) begin
         if (r_state == WAIT_DS) begin
            // Slot 0 is the delay slot; slot 1 is always discarded
            if (w_live0) begin
               if (u0_causeExc) begin
                  w_exc      = 1'b1;
                  w_exc_code = u0_exception;
                  w_exc_epc  = u0_pc;
               end else begin
                  w_ret0     = 1'b1;
                  w_br_flush = 1'b1;
                  w_br_tgt   = r_target;
               end
            end
         end else if (w_live0 && u0_causeExc) begin
            w_exc      = 1'b1;
            w_exc_code = u0_exception;
            w_exc_epc  = u0_pc;
         end else begin
            w_ret0 = w_live0;
            if (w_live0 && w_mis0) begin
               if (w_live1) begin
                  // Slot 1 is the branch's delay slot
                  if (u1_causeExc) begin
                     w_exc      = 1'b1;
                     w_exc_code = u1_exception;
                     w_exc_epc  = u1_pc;
                  end else begin
                     w_ret1     = 1'b1;
                     w_br_flush = 1'b1;
                     w_br_tgt   = w_tgt0;
                  end
               end else begin
                  w_to_wait = 1'b1;
                  w_br_tgt  = w_tgt0;
               end
            end else if (w_live1) begin
               if (u1_causeExc) begin
                  w_exc      = 1'b1;
                  w_exc_code = u1_exception;
                  w_exc_epc  = u1_pc;
               end else begin
                  w_ret1 = 1'b1;
                  if (w_mis1) begin
                     w_to_wait = 1'b1;
                     w_br_tgt  = w_tgt1;
                  end
               end
            end
         end
      end
   end

   logic w_we0, w_we1;
   assign w_we0 = w_ret0 && u0_wen;
   assign w_we1 = w_ret1 && u1_wen;

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= NORMAL;
         r_target         <= 32'd0;
         r_arat_we        <= 2'd0;
         r_arat_l0        <= '0;
         r_arat_p0        <= '0;
         r_arat_l1        <= '0;
         r_arat_p1        <= '0;
         r_free_we        <= 2'd0;
         r_free_p0        <= '0;
         r_free_p1        <= '0;
         r_store_commit   <= 2'd0;
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_exc_valid      <= 1'b0;
         r_exc_code       <= 5'd0;
         r_exc_epc        <= 32'd0;
      end else begin
         r_arat_we      <= {w_we1, w_we0};
         r_arat_l0      <= w_we0 ? u0_dstL : '0;
         r_arat_p0      <= w_we0 ? u0_dstP : '0;
         r_arat_l1      <= w_we1 ? u1_dstL : '0;
         r_arat_p1      <= w_we1 ? u1_dstP : '0;
         r_free_we      <= {w_we1, w_we0};
         r_free_p0      <= w_we0 ? u0_oldP : '0;
         r_free_p1      <= w_we1 ? u1_oldP : '0;
         r_store_commit <= 2'(w_ret0 && u0_isStore) + 2'(w_ret1 && u1_isStore);

         // Flush-cycle outputs are single-cycle pulses
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_exc_valid      <= 1'b0;
         r_exc_code       <= 5'd0;
         r_exc_epc        <= 32'd0;

         case (r_state)
            NORMAL, WAIT_DS: begin
               if (w_exc) begin
                  r_state          <= FLUSH;
                  r_target         <= 32'd0;
                  r_flush          <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_redirect_pc    <= EXC_VECTOR;
                  r_exc_valid      <= 1'b1;
                  r_exc_code       <= w_exc_code;
                  r_exc_epc        <= w_exc_epc;
               end else if (w_br_flush) begin
                  r_state          <= FLUSH;
                  r_target         <= 32'd0;
                  r_flush          <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_redirect_pc    <= w_br_tgt;
               end else if (w_to_wait) begin
                  r_state  <= WAIT_DS;
                  r_target <= w_br_tgt;
               end
            end
            default: r_state <= NORMAL;
         endcase
      end
   end

   assign rob_ready      = (r_state != FLUSH);
   assign arat_we        = r_arat_we;
   assign arat_l0        = r_arat_l0;
   assign arat_p0        = r_arat_p0;
   assign arat_l1        = r_arat_l1;
   assign arat_p1        = r_arat_p1;
   assign free_we        = r_free_we;
   assign free_p0        = r_free_p0;
   assign free_p1        = r_free_p1;
   assign store_commit   = r_store_commit;
   assign flush          = r_flush;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign exc_valid      = r_exc_valid;
   assign exc_code       = r_exc_code;
   assign exc_epc        = r_exc_epc;

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed self-checking bench for commit_unit.
module tb_commit_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rob_valid;
   logic        rob_ready;
   logic        u0_valid, u0_committed, u0_wen, u0_isBranch, u0_branchTaken, u0_predTaken;
   logic        u0_causeExc, u0_isStore;
   logic [31:0] u0_pc, u0_branchAddr, u0_predAddr;
   logic [4:0]  u0_dstL, u0_exception;
   logic [5:0]  u0_dstP, u0_oldP;
   logic        u1_valid, u1_committed, u1_wen, u1_isBranch, u1_branchTaken, u1_predTaken;
   logic        u1_causeExc, u1_isStore;
   logic [31:0] u1_pc, u1_branchAddr, u1_predAddr;
   logic [4:0]  u1_dstL, u1_exception;
   logic [5:0]  u1_dstP, u1_oldP;
   logic [1:0]  arat_we, free_we, store_commit;
   logic [4:0]  arat_l0, arat_l1, exc_code;
   logic [5:0]  arat_p0, arat_p1, free_p0, free_p1;
   logic        flush, redirect_valid, exc_valid;
   logic [31:0] redirect_pc, exc_epc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   commit_unit dut (
      .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_ready(rob_ready),
      .u0_valid(u0_valid), .u0_committed(u0_committed), .u0_pc(u0_pc), .u0_wen(u0_wen),
      .u0_dstL(u0_dstL), .u0_dstP(u0_dstP), .u0_oldP(u0_oldP), .u0_isBranch(u0_isBranch),
      .u0_branchTaken(u0_branchTaken), .u0_predTaken(u0_predTaken),
      .u0_branchAddr(u0_branchAddr), .u0_predAddr(u0_predAddr), .u0_causeExc(u0_causeExc),
      .u0_exception(u0_exception), .u0_isStore(u0_isStore),
      .u1_valid(u1_valid), .u1_committed(u1_committed), .u1_pc(u1_pc), .u1_wen(u1_wen),
      .u1_dstL(u1_dstL), .u1_dstP(u1_dstP), .u1_oldP(u1_oldP), .u1_isBranch(u1_isBranch),
      .u1_branchTaken(u1_branchTaken), .u1_predTaken(u1_predTaken),
      .u1_branchAddr(u1_branchAddr), .u1_predAddr(u1_predAddr), .u1_causeExc(u1_causeExc),
      .u1_exception(u1_exception), .u1_isStore(u1_isStore),
      .arat_we(arat_we), .arat_l0(arat_l0), .arat_p0(arat_p0), .arat_l1(arat_l1),
      .arat_p1(arat_p1), .free_we(free_we), .free_p0(free_p0), .free_p1(free_p1),
      .store_commit(store_commit), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc)
   );

   task automatic clear_inputs();
      rob_valid = 0;
      u0_valid = 0; u0_committed = 0; u0_pc = 0; u0_wen = 0; u0_dstL = 0; u0_dstP = 0;
      u0_oldP = 0; u0_isBranch = 0; u0_branchTaken = 0; u0_predTaken = 0;
      u0_branchAddr = 0; u0_predAddr = 0; u0_causeExc = 0; u0_exception = 0; u0_isStore = 0;
      u1_valid = 0; u1_committed = 0; u1_pc = 0; u1_wen = 0; u1_dstL = 0; u1_dstP = 0;
      u1_oldP = 0; u1_isBranch = 0; u1_branchTaken = 0; u1_predTaken = 0;
      u1_branchAddr = 0; u1_predAddr = 0; u1_causeExc = 0; u1_exception = 0; u1_isStore = 0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      n_checks++; if (rob_ready !== 1'b1) begin n_errors++; $display("FAIL reset_rob_ready: got %b expected 1", rob_ready); end
      n_checks++; if (arat_we !== 2'b00 || free_we !== 2'b00 || store_commit !== 2'd0) begin n_errors++; $display("FAIL reset_retire: got arat_we=%b free_we=%b store=%0d expected all 0", arat_we, free_we, store_commit); end
      n_checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || exc_valid !== 1'b0 || redirect_pc !== 32'd0 || exc_code !== 5'd0 || exc_epc !== 32'd0) begin n_errors++; $display("FAIL reset_flush: got flush=%b rv=%b ev=%b rpc=%h code=%h epc=%h expected all 0", flush, redirect_valid, exc_valid, redirect_pc, exc_code, exc_epc); end
   endtask

   task automatic test_alu_pair();
      rob_valid = 1;
      u0_valid = 1; u0_wen = 1; u0_dstL = 3; u0_dstP = 40; u0_oldP = 3; u0_pc = 32'h80000000;
      u1_valid = 1; u1_wen = 1; u1_dstL = 4; u1_dstP = 41; u1_oldP = 4; u1_pc = 32'h80000004;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b11 || arat_l0 !== 5'd3 || arat_p0 !== 6'd40 || arat_l1 !== 5'd4 || arat_p1 !== 6'd41) begin n_errors++; $display("FAIL alu_arat: got we=%b l0=%0d p0=%0d l1=%0d p1=%0d expected 11 3 40 4 41", arat_we, arat_l0, arat_p0, arat_l1, arat_p1); end
      n_checks++; if (free_we !== 2'b11 || free_p0 !== 6'd3 || free_p1 !== 6'd4) begin n_errors++; $display("FAIL alu_free: got we=%b p0=%0d p1=%0d expected 11 3 4", free_we, free_p0, free_p1); end
      n_checks++; if (flush !== 1'b0 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL alu_noflush: got flush=%b ready=%b expected 0 1", flush, rob_ready); end
      tick();
      n_checks++; if (arat_we !== 2'b00 || free_we !== 2'b00) begin n_errors++; $display("FAIL alu_idle: got arat_we=%b free_we=%b expected 00 00", arat_we, free_we); end
   endtask

   task automatic test_empty_beat();
      rob_valid = 1;
      u0_valid = 1; u0_committed = 1; u0_wen = 1; u0_dstL = 9; u0_dstP = 50; u0_isStore = 1;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b00 || store_commit !== 2'd0 || flush !== 1'b0 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL empty_beat: got we=%b store=%0d flush=%b ready=%b expected 00 0 0 1", arat_we, store_commit, flush, rob_ready); end
   endtask

   task automatic test_exception();
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80001000; u0_causeExc = 1; u0_exception = 5'h04; u0_wen = 1; u0_dstL = 2; u0_dstP = 33;
      u1_valid = 1; u1_pc = 32'h80001004; u1_isStore = 1; u1_wen = 1; u1_dstL = 5; u1_dstP = 34;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b00 || free_we !== 2'b00 || store_commit !== 2'd0) begin n_errors++; $display("FAIL exc_noretire: got we=%b free=%b store=%0d expected 00 00 0", arat_we, free_we, store_commit); end
      n_checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || exc_valid !== 1'b1 || rob_ready !== 1'b0) begin n_errors++; $display("FAIL exc_flush: got flush=%b rv=%b ev=%b ready=%b expected 1 1 1 0", flush, redirect_valid, exc_valid, rob_ready); end
      n_checks++; if (exc_code !== 5'h04 || exc_epc !== 32'h80001000 || redirect_pc !== 32'hBFC00380) begin n_errors++; $display("FAIL exc_info: got code=%h epc=%h rpc=%h expected 04 80001000 bfc00380", exc_code, exc_epc, redirect_pc); end
      tick();
      n_checks++; if (rob_ready !== 1'b1 || flush !== 1'b0 || exc_valid !== 1'b0) begin n_errors++; $display("FAIL exc_resume: got ready=%b flush=%b ev=%b expected 1 0 0", rob_ready, flush, exc_valid); end
   endtask

   task automatic test_branch_slot0();
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80000100; u0_isBranch = 1; u0_predTaken = 0; u0_branchTaken = 1;
      u0_branchAddr = 32'h80000200; u0_predAddr = 32'h80000108;
      u1_valid = 1; u1_pc = 32'h80000104; u1_wen = 1; u1_dstL = 7; u1_dstP = 45; u1_oldP = 20;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b10 || arat_p1 !== 6'd45 || free_p1 !== 6'd20) begin n_errors++; $display("FAIL br0_retire: got we=%b p1=%0d free_p1=%0d expected 10 45 20", arat_we, arat_p1, free_p1); end
      n_checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || exc_valid !== 1'b0 || redirect_pc !== 32'h80000200) begin n_errors++; $display("FAIL br0_flush: got flush=%b rv=%b ev=%b rpc=%h expected 1 1 0 80000200", flush, redirect_valid, exc_valid, redirect_pc); end
      tick();
      n_checks++; if (rob_ready !== 1'b1 || flush !== 1'b0) begin n_errors++; $display("FAIL br0_resume: got ready=%b flush=%b expected 1 0", rob_ready, flush); end
   endtask

   task automatic test_branch_waitds();
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80000100; u0_wen = 1; u0_dstL = 5; u0_dstP = 42; u0_oldP = 5;
      u1_valid = 1; u1_pc = 32'h80000104; u1_isBranch = 1; u1_predTaken = 1; u1_branchTaken = 0;
      u1_predAddr = 32'h80000300; u1_branchAddr = 32'h80000300;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b01 || arat_p0 !== 6'd42 || flush !== 1'b0 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL ds_first: got we=%b p0=%0d flush=%b ready=%b expected 01 42 0 1", arat_we, arat_p0, flush, rob_ready); end
      tick();
      n_checks++; if (flush !== 1'b0 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL ds_idle: got flush=%b ready=%b expected 0 1", flush, rob_ready); end
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80000108; u0_wen = 1; u0_dstL = 6; u0_dstP = 43; u0_oldP = 6; u0_isStore = 1;
      u1_valid = 1; u1_pc = 32'h8000010C; u1_wen = 1; u1_dstL = 7; u1_dstP = 44; u1_oldP = 7; u1_isStore = 1;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b01 || arat_p0 !== 6'd43 || free_p0 !== 6'd6 || store_commit !== 2'd1) begin n_errors++; $display("FAIL ds_retire: got we=%b p0=%0d free_p0=%0d store=%0d expected 01 43 6 1", arat_we, arat_p0, free_p0, store_commit); end
      n_checks++; if (flush !== 1'b1 || exc_valid !== 1'b0 || redirect_pc !== 32'h8000010C || rob_ready !== 1'b0) begin n_errors++; $display("FAIL ds_flush: got flush=%b ev=%b rpc=%h ready=%b expected 1 0 8000010c 0", flush, exc_valid, redirect_pc, rob_ready); end
      tick();
      n_checks++; if (rob_ready !== 1'b1 || flush !== 1'b0) begin n_errors++; $display("FAIL ds_resume: got ready=%b flush=%b expected 1 0", rob_ready, flush); end
   endtask

   task automatic test_waitds_exception();
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80000400; u0_isBranch = 1; u0_predTaken = 0; u0_branchTaken = 1;
      u0_branchAddr = 32'h80000500;
      tick();
      clear_inputs();
      n_checks++; if (flush !== 1'b0 || arat_we !== 2'b00 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL dsx_first: got flush=%b we=%b ready=%b expected 0 00 1", flush, arat_we, rob_ready); end
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80000404; u0_causeExc = 1; u0_exception = 5'h0A; u0_wen = 1; u0_dstL = 8; u0_dstP = 46;
      tick();
      clear_inputs();
      n_checks++; if (arat_we !== 2'b00 || flush !== 1'b1 || exc_valid !== 1'b1) begin n_errors++; $display("FAIL dsx_flush: got we=%b flush=%b ev=%b expected 00 1 1", arat_we, flush, exc_valid); end
      n_checks++; if (redirect_pc !== 32'hBFC00380 || exc_code !== 5'h0A || exc_epc !== 32'h80000404) begin n_errors++; $display("FAIL dsx_info: got rpc=%h code=%h epc=%h expected bfc00380 0a 80000404", redirect_pc, exc_code, exc_epc); end
      tick();
   endtask

   task automatic test_stores_committed();
      rob_valid = 1;
      u0_valid = 1; u0_committed = 1; u0_isStore = 1;
      u1_valid = 1; u1_isStore = 1;
      tick();
      clear_inputs();
      n_checks++; if (store_commit !== 2'd1 || free_we !== 2'b00) begin n_errors++; $display("FAIL store_one: got store=%0d free_we=%b expected 1 00", store_commit, free_we); end
      rob_valid = 1;
      u0_valid = 1; u0_isStore = 1;
      u1_valid = 1; u1_isStore = 1;
      tick();
      clear_inputs();
      n_checks++; if (store_commit !== 2'd2) begin n_errors++; $display("FAIL store_two: got store=%0d expected 2", store_commit); end
   endtask

   task automatic test_reset_midflight();
      // Reset during FLUSH
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80002000; u0_causeExc = 1; u0_exception = 5'h0C;
      tick();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
      n_checks++; if (flush !== 1'b0 || exc_valid !== 1'b0 || redirect_valid !== 1'b0 || exc_code !== 5'd0 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL rst_flush: got flush=%b ev=%b rv=%b code=%h ready=%b expected 0 0 0 0 1", flush, exc_valid, redirect_valid, exc_code, rob_ready); end
      // Reset during WAIT_DS drops the pending redirect
      rob_valid = 1;
      u0_valid = 1; u0_pc = 32'h80003000; u0_isBranch = 1; u0_predTaken = 0; u0_branchTaken = 1;
      u0_branchAddr = 32'h80003100;
      tick();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
      rob_valid = 1;
      u0_valid = 1; u0_wen = 1; u0_dstL = 1; u0_dstP = 47; u0_oldP = 1;
      tick();
      clear_inputs();
      n_checks++; if (flush !== 1'b0 || arat_we !== 2'b01 || arat_p0 !== 6'd47 || rob_ready !== 1'b1) begin n_errors++; $display("FAIL rst_waitds: got flush=%b we=%b p0=%0d ready=%b expected 0 01 47 1", flush, arat_we, arat_p0, rob_ready); end
      // Reset coincident with a beat suppresses its side effects
      rob_valid = 1; rst = 1;
      u0_valid = 1; u0_wen = 1; u0_dstL = 2; u0_dstP = 48; u0_isStore = 1;
      tick();
      clear_inputs();
      rst = 0;
      n_checks++; if (arat_we !== 2'b00 || store_commit !== 2'd0) begin n_errors++; $display("FAIL rst_beat: got we=%b store=%0d expected 00 0", arat_we, store_commit); end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_alu_pair();
      test_empty_beat();
      test_exception();
      test_branch_slot0();
      test_branch_waitds();
      test_waitds_exception();
      test_stores_committed();
      test_reset_midflight();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
